// File: rtl/fp_pkg.sv
// Shared constants and types for the FPU divider.
//   QNAN          canonical quiet NaN returned for invalid operations
//   BIAS          binary32 exponent bias
//   RM_*          RISC-V rounding-mode encodings (101-111 behave as RNE)
//   div_state_t   divider FSM states
package fp_pkg;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam int          BIAS = 127;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        ROUND,
        FIN
    } div_state_t;

endpackage

// File: rtl/fp_div_special.sv
// Combinational operand classifier for the divider.
// Denormals are treated as zero.
//   num_a_i / num_b_i   dividend / divisor (binary32)
//   is_special_o        result is fully determined without dividing
//   special_result_o    that result (valid when is_special_o)
//   invalid_o           NaN operand, 0/0 or inf/inf
//   divzero_o           finite nonzero / zero
module fp_div_special (
    input  logic [31:0] num_a_i,
    input  logic [31:0] num_b_i,
    output logic        is_special_o,
    output logic [31:0] special_result_o,
    output logic        invalid_o,
    output logic        divzero_o
);
    import fp_pkg::*;

    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;
    logic sign;

    assign a_zero = (num_a_i[30:23] == 8'h00);
    assign a_inf  = (num_a_i[30:23] == 8'hFF) && (num_a_i[22:0] == 23'd0);
    assign a_nan  = (num_a_i[30:23] == 8'hFF) && (num_a_i[22:0] != 23'd0);
    assign b_zero = (num_b_i[30:23] == 8'h00);
    assign b_inf  = (num_b_i[30:23] == 8'hFF) && (num_b_i[22:0] == 23'd0);
    assign b_nan  = (num_b_i[30:23] == 8'hFF) && (num_b_i[22:0] != 23'd0);
    assign sign   = num_a_i[31] ^ num_b_i[31];

    always_comb begin
        is_special_o     = 1'b1;
        special_result_o = QNAN;
        invalid_o        = 1'b0;
        divzero_o        = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            invalid_o = 1'b1;
        end else if (a_inf) begin
            // inf/x, including inf/0, is a plain signed infinity
            special_result_o = {sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            special_result_o = {sign, 8'hFF, 23'd0};
            divzero_o        = 1'b1;
        end else if (a_zero || b_inf) begin
            special_result_o = {sign, 31'd0};
        end else begin
            is_special_o     = 1'b0;
            special_result_o = 32'd0;
        end
    end

endmodule

// File: rtl/fp_div.sv
// Iterative binary32 divider: Result = Num_A / Num_B, restoring radix-2, one
// quotient bit per cycle, start/done handshake.
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only in IDLE
//   Num_A, Num_B, R_M   operands and rounding mode, captured on acceptance
//   busy                high from acceptance through the done cycle
//   done                one-cycle pulse; Result/flags valid and held after
//   Result              quotient
//   OverFlow, DivZero, Invalid   exception flags
module fp_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] Num_A,
    input  logic [31:0] Num_B,
    input  logic [2:0]  R_M,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic        OverFlow,
    output logic        DivZero,
    output logic        Invalid
);
    import fp_pkg::*;

    div_state_t        state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [2:0]        rm_q, rm_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [23:0]       mb_q, mb_d;
    logic [24:0]       rem_q, rem_d;
    logic [25:0]       quo_q, quo_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       pres_q, pres_d;     // pending result, published in FIN
    logic [2:0]        pflag_q, pflag_d;   // {overflow, divzero, invalid}
    logic [31:0]       result_q, result_d;
    logic [2:0]        flag_q, flag_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic        is_special, sp_invalid, sp_divzero;
    logic [31:0] special_result;

    fp_div_special u_special (
        .num_a_i          (a_q),
        .num_b_i          (b_q),
        .is_special_o     (is_special),
        .special_result_o (special_result),
        .invalid_o        (sp_invalid),
        .divzero_o        (sp_divzero)
    );

    // Unpack
    logic [23:0]       ma, mb;
    logic signed [9:0] exp_raw;

    assign ma      = {1'b1, a_q[22:0]};
    assign mb      = {1'b1, b_q[22:0]};
    assign exp_raw = {2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'(BIAS);

    // Restoring step
    logic [24:0] mb_ext;
    logic        rem_ge;

    assign mb_ext = {1'b0, mb_q};
    assign rem_ge = (rem_q >= mb_ext);

    // Rounding: quo_q[25:2] mantissa, [1] guard, [0] round, remainder gives sticky
    logic              lsb, guard, rs, inc, max_finite, round_ovf;
    logic [24:0]       mant;
    logic signed [9:0] exp_rnd;
    logic [22:0]       frac;
    logic [31:0]       round_res;

    assign lsb   = quo_q[2];
    assign guard = quo_q[1];
    assign rs    = quo_q[0] | (rem_q != 25'd0);

    always_comb begin
        unique case (rm_q)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign_q & (guard | rs);
            RM_RUP:  inc = ~sign_q & (guard | rs);
            RM_RMM:  inc = guard;
            default: inc = guard & (rs | lsb);
        endcase
    end

    assign mant    = {1'b0, quo_q[25:2]} + {24'd0, inc};
    // Carry-out only happens from all-ones, so the renormalised fraction is zero
    assign exp_rnd = exp_q + {9'd0, mant[24]};
    assign frac    = mant[24] ? mant[23:1] : mant[22:0];
    // Modes that never round away from zero saturate to max-finite
    assign max_finite = (rm_q == RM_RTZ) || ((rm_q == RM_RDN) && !sign_q)
                     || ((rm_q == RM_RUP) && sign_q);

    always_comb begin
        round_ovf = 1'b0;
        round_res = {sign_q, 31'd0};
        if (exp_rnd >= 10'sd255) begin
            round_ovf = 1'b1;
            round_res = max_finite ? {sign_q, 31'h7F7F_FFFF} : {sign_q, 8'hFF, 23'd0};
        end else if (exp_rnd > 10'sd0) begin
            round_res = {sign_q, exp_rnd[7:0], frac};
        end
    end

    // FSM and datapath next state
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rm_d     = rm_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mb_d     = mb_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        pres_d   = pres_q;
        pflag_d  = pflag_q;
        result_d = result_q;
        flag_d   = flag_q;
        done_d   = 1'b0;
        busy_d   = done_q ? 1'b0 : busy_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = Num_A;
                    b_d     = Num_B;
                    rm_d    = R_M;
                    flag_d  = 3'b000;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                sign_d = a_q[31] ^ b_q[31];
                if (is_special) begin
                    pres_d  = special_result;
                    pflag_d = {1'b0, sp_divzero, sp_invalid};
                    state_d = FIN;
                end else begin
                    // Pre-shift so the first quotient bit is always the integer 1
                    if (ma < mb) begin
                        rem_d = {ma, 1'b0};
                        exp_d = exp_raw - 10'sd1;
                    end else begin
                        rem_d = {1'b0, ma};
                        exp_d = exp_raw;
                    end
                    mb_d    = mb;
                    quo_d   = 26'd0;
                    cnt_d   = 5'd25;
                    pflag_d = 3'b000;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (rem_ge) begin
                    quo_d = {quo_q[24:0], 1'b1};
                    rem_d = (rem_q - mb_ext) << 1;
                end else begin
                    quo_d = {quo_q[24:0], 1'b0};
                    rem_d = rem_q << 1;
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                pres_d  = round_res;
                pflag_d = {round_ovf, 2'b00};
                state_d = FIN;
            end
            FIN: begin
                result_d = pres_q;
                flag_d   = pflag_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rm_q     <= 3'd0;
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            mb_q     <= 24'd0;
            rem_q    <= 25'd0;
            quo_q    <= 26'd0;
            cnt_q    <= 5'd0;
            pres_q   <= 32'd0;
            pflag_q  <= 3'd0;
            result_q <= 32'd0;
            flag_q   <= 3'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rm_q     <= rm_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mb_q     <= mb_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            pres_q   <= pres_d;
            pflag_q  <= pflag_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Result   = result_q;
    assign OverFlow = flag_q[2];
    assign DivZero  = flag_q[1];
    assign Invalid  = flag_q[0];

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed cases plus randomized operands
// against an arithmetic reference model.
module tb_fp_div;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] Num_A = 32'd0;
    logic [31:0] Num_B = 32'd0;
    logic [2:0]  R_M   = 3'd0;
    logic        busy, done, OverFlow, DivZero, Invalid;
    logic [31:0] Result;

    int n_vec = 0;
    int n_err = 0;

    fp_div dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .Num_A    (Num_A),
        .Num_B    (Num_B),
        .R_M      (R_M),
        .busy     (busy),
        .done     (done),
        .Result   (Result),
        .OverFlow (OverFlow),
        .DivZero  (DivZero),
        .Invalid  (Invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer quotient of the significands, then IEEE rounding.
    // Flags are {OverFlow, DivZero, Invalid}.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] rm, output logic [31:0] r,
                                    output logic [2:0] fl, output int lat);
        int              ea, eb, e;
        bit              s, za, zb, ia, ib, na, nb, g, st, up;
        longint unsigned ma, mb, num, q, rr, mant;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        fl  = 3'b000;
        lat = 2;
        if (na || nb || (za && zb) || (ia && ib)) begin
            r  = 32'h7FC0_0000;
            fl = 3'b001;
        end else if (ia) begin
            r = {s, 8'hFF, 23'd0};
        end else if (zb) begin
            r  = {s, 8'hFF, 23'd0};
            fl = 3'b010;
        end else if (za || ib) begin
            r = {s, 31'd0};
        end else begin
            lat = 29;
            ma  = {40'd1, a[22:0]};
            mb  = {40'd1, b[22:0]};
            e   = ea - eb + 127;
            num = ma << 26;
            q   = num / mb;
            rr  = num % mb;
            if (q >= (64'd1 << 26)) begin
                mant = q >> 3;
                g    = q[2];
                st   = (q[1:0] != 2'b00) || (rr != 0);
            end else begin
                e    = e - 1;
                mant = q >> 2;
                g    = q[1];
                st   = q[0] || (rr != 0);
            end
            case (rm)
                3'd1:    up = 1'b0;
                3'd2:    up = s && (g || st);
                3'd3:    up = !s && (g || st);
                3'd4:    up = g;
                default: up = g && (st || mant[0]);
            endcase
            mant = mant + longint'(up);
            if (mant == (64'd1 << 24)) begin
                mant = mant >> 1;
                e    = e + 1;
            end
            if (e >= 255) begin
                fl = 3'b100;
                if (rm == 3'd1 || (rm == 3'd2 && !s) || (rm == 3'd3 && s))
                    r = {s, 31'h7F7F_FFFF};
                else
                    r = {s, 8'hFF, 23'd0};
            end else if (e <= 0) begin
                r = {s, 31'd0};
            end else begin
                r = {s, 8'(e), mant[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 19);
        case (k)
            0:       v[30:0] = 31'd0;
            1:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3:       v[30:23] = 8'h00;
            4:       v[30:23] = 8'($urandom_range(230, 254));
            5:       v[30:23] = 8'($urandom_range(1, 25));
            6:       begin v[30:23] = 8'($urandom_range(100, 154)); v[22:0] = 23'h7F_FFFF; end
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // One operation; inputs are scrambled while busy, optional stray starts at
    // cycles 5 and 10.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] rm, input logic [31:0] exp_r,
                          input logic [2:0] exp_f, input int exp_lat, input bit poke);
        int lat;
        @(negedge clk);
        Num_A = a;
        Num_B = b;
        R_M   = rm;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".busy_acc"}, 32'(busy), 32'd1);
        check({tag, ".flags_clr"}, 32'({OverFlow, DivZero, Invalid}), 32'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 64) begin
            @(negedge clk);
            Num_A = $urandom;
            Num_B = $urandom;
            R_M   = 3'($urandom);
            start = poke && (lat == 5 || lat == 10);
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".result"}, Result, exp_r);
        check({tag, ".flags"}, 32'({OverFlow, DivZero, Invalid}), 32'(exp_f));
        check({tag, ".busy_done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, 32'({done, busy}), 32'd0);
        check({tag, ".hold"}, Result, exp_r);
    endtask

    initial begin
        logic [31:0] a, b, r;
        logic [2:0]  rm, f;
        int          lat, seen;

        repeat (2) @(posedge clk);
        #1;
        check("reset.result", Result, 32'd0);
        check("reset.ctl", 32'({busy, done, OverFlow, DivZero, Invalid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("six_by_two", 32'h40C0_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 3'b000, 29, 0);
        run_op("third_rne",  32'h3F80_0000, 32'h4040_0000, 3'd0, 32'h3EAA_AAAB, 3'b000, 29, 0);
        run_op("third_rtz",  32'h3F80_0000, 32'h4040_0000, 3'd1, 32'h3EAA_AAAA, 3'b000, 29, 0);
        run_op("third_rup",  32'h3F80_0000, 32'h4040_0000, 3'd3, 32'h3EAA_AAAB, 3'b000, 29, 0);
        run_op("one_by_0",   32'h3F80_0000, 32'h0000_0000, 3'd0, 32'h7F80_0000, 3'b010, 2, 0);
        run_op("zero_by_0",  32'h0000_0000, 32'h0000_0000, 3'd0, 32'h7FC0_0000, 3'b001, 2, 0);
        run_op("ovf_rne",    32'h7F00_0000, 32'h3E80_0000, 3'd0, 32'h7F80_0000, 3'b100, 29, 0);
        run_op("ovf_rtz",    32'h7F00_0000, 32'h3E80_0000, 3'd1, 32'h7F7F_FFFF, 3'b100, 29, 0);
        run_op("stray_start", 32'h40C0_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 3'b000, 29, 1);

        for (int i = 0; i < 120; i++) begin
            a  = rand_fp();
            b  = rand_fp();
            rm = 3'($urandom_range(0, 7));
            ref_div(a, b, rm, r, f, lat);
            run_op($sformatf("rnd%0d_%h_%h_%0d", i, a, b, rm), a, b, rm, r, f, lat, 0);
        end

        // Abort mid-division
        @(negedge clk);
        Num_A = 32'h40C0_0000;
        Num_B = 32'h4000_0000;
        R_M   = 3'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.result", Result, 32'd0);
        check("abort.ctl", 32'({busy, done, OverFlow, DivZero, Invalid}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        check("abort.no_done", 32'(seen), 32'd0);
        run_op("after_abort", 32'h40C0_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 3'b000, 29, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
